chip8_rom_loader: RTL
=====================

Name: chip8_rom_loader

Overview:
Sits between the hps_io download port and the chip8 machine's program RAM write port. On each CH8 download it clears program space 0x200–0xFFF, then streams incoming bytes to 0x200 plus the byte offset. It throttles hps_io with ioctl_wait, holds the CPU off via mem_busy, and reports ROM size and overflow. Its load_done pulse feeds the top-level reset sequencer.

Parameters:
BASE_ADDR, 12'h200, first program byte address; clear region starts here.
MEM_TOP, 12'hFFF, last writable address; clear region ends here.
CLEAR_VALUE, 8'h00, fill byte written during clear.

Ports:
clk_sys  in  1  system clock, 50 MHz; all logic on posedge.
reset_n  in  1  synchronous active-low reset.
ioctl_download  in  1  download active, from hps_io.
ioctl_wr  in  1  one-cycle byte strobe, from hps_io.
ioctl_addr  in  25  byte offset within file.
ioctl_dout  in  8  download byte.
ioctl_wait  out  1  stall request to hps_io.
mem_we  out  1  RAM write strobe.
mem_addr  out  12  RAM write address.
mem_data  out  8  RAM write data.
mem_busy  out  1  high while loader owns RAM; chip8 CPU must not run.
load_done  out  1  one-cycle pulse when a load completes.
rom_size  out  12  bytes accepted in the last load, saturating at MEM_TOP-BASE_ADDR+1 (3584).
overflow  out  1  sticky; at least one byte beyond MEM_TOP was dropped in the current or last load.

Behaviour:
- Reset (reset_n=0 at posedge):
  - State IDLE.
  - All outputs 0; rom_size=0; hold register empty.
  - Reset mid-load abandons the load without a load_done pulse; RAM contents are left as they are.
- Download start detection: on a registered rising edge of ioctl_download, the block clears overflow and rom_size, then enters CLEAR.
- States:
  - IDLE: mem_busy=0, ioctl_wait=0. An ioctl_wr in IDLE is ignored.
  - CLEAR:
    - mem_busy=1, ioctl_wait=1.
    - mem_we=1 every cycle, mem_data=CLEAR_VALUE, mem_addr walks BASE_ADDR..MEM_TOP, one address per cycle (3584 cycles).
    - After MEM_TOP the block goes to FONT if the optional feature is built in, otherwise to LOAD.
  - LOAD:
    - mem_busy=1, ioctl_wait=0.
    - ioctl_wr with ioctl_addr < 3584: next cycle mem_we=1, mem_addr=BASE_ADDR+ioctl_addr[11:0], mem_data=ioctl_dout (latency 1). rom_size=max(rom_size, ioctl_addr+1).
    - ioctl_wr with ioctl_addr >= 3584: byte dropped, no mem_we, overflow<=1.
  - DONE: one cycle. load_done=1, then IDLE.
- Hold register (one entry):
  - A byte strobed in the same cycle as the download rising edge, or while ioctl_wait is still rising, is captured.
  - It is written on the first LOAD cycle, before any new strobe. A strobe arriving in that same cycle is delayed one cycle; ioctl_wait is held 1 for that cycle.
- Download end:
  - Falling edge of ioctl_download in LOAD: drain the hold register if occupied, then DONE.
  - Falling edge during CLEAR or FONT: complete the clear/font fully, drain the hold register, then DONE.
  - ioctl_wait is never left asserted in IDLE.
- Back-to-back downloads: a new rising edge seen in DONE or later restarts from CLEAR.
- mem_we is never asserted in IDLE or DONE.
- Address arithmetic is 12-bit. BASE_ADDR+offset cannot wrap, because offsets ≥ 3584 are rejected first.

Optional Feature:
Macro CHIP8_FONT_PRELOAD_EN.
- When defined: after CLEAR the block enters FONT, with mem_busy=1 and ioctl_wait=1. It writes the standard 80-byte hex font (digits 0–F, 5 bytes each; digit 0 = F0 90 90 90 F0) to 0x000–0x04F, one byte per cycle, then enters LOAD. Font ROM is internal.
- When undefined: FONT state and ROM are absent; CLEAR goes directly to LOAD, and font is assumed pre-initialised in chip8 RAM.

Test Plan:
- Clear sweep: raise ioctl_download with no writes, drop it after 4000 cycles → 3584 mem_we with data 00 at 0x200..0xFFF, ioctl_wait=1 throughout CLEAR, one load_done, rom_size=0.
- Basic load: 3 strobes at offsets 0,1,2 with data A2,2A,60 during LOAD → writes 0x200=A2, 0x201=2A, 0x202=60 each one cycle after its strobe; rom_size=3; overflow=0.
- Overflow: strobes at offsets 3583 and 3584 → only 0xFFF written; overflow=1; rom_size=3584; overflow clears at next download start.
- Early strobe: ioctl_wr at offset 0 (data 12) on the same cycle as the download rising edge → byte 12 written to 0x200 on the first LOAD cycle, after the clear, not overwritten by the clear.
- Reset mid-clear: reset_n=0 at clear address 0x400 → next cycle mem_we=0, mem_busy=0, ioctl_wait=0, no load_done.
- Font (CHIP8_FONT_PRELOAD_EN): one download → writes 0x000=F0, 0x004=F0, 0x04F=80 occur between the end of CLEAR and entry to LOAD.

Source files
------------

// File: rtl/chip8_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : chip8_rom_loader
//  Purpose  : Clears CHIP-8 program RAM, then streams hps_io download bytes
//             into it. Optional font preload via CHIP8_FONT_PRELOAD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module chip8_rom_loader #(
  parameter logic [11:0] BASE_ADDR   = 12'h200,
  parameter logic [11:0] MEM_TOP     = 12'hFFF,
  parameter logic [7:0]  CLEAR_VALUE = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_busy,
  output logic        load_done,
  output logic [11:0] rom_size,
  output logic        overflow
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
`ifdef CHIP8_FONT_PRELOAD_EN
    ST_FONT  = 3'd2,
`endif
    ST_LOAD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [24:0] c_span = 25'(MEM_TOP) - 25'(BASE_ADDR) + 25'd1;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_dl_q;
  logic [11:0] r_clr_addr;
  logic        r_hold_vld;
  logic [11:0] r_hold_addr;
  logic [7:0]  r_hold_data;
  logic        r_wr_vld;
  logic [11:0] r_wr_addr;
  logic [7:0]  r_wr_data;
  logic [11:0] r_rom_size;
  logic        r_overflow;

  logic        w_rise;
  logic        w_start;
  logic        w_prefill;
  logic        w_in_range;
  logic [11:0] w_off_addr;
  logic [11:0] w_off_p1;
  logic        w_take;
  logic        w_capture;
  logic        w_direct;
  logic [11:0] w_size_base;
  logic        w_ovf_base;

`ifdef CHIP8_FONT_PRELOAD_EN
  // Standard hex glyphs 0..F, 5 bytes each, byte 0 in the top bits.
  localparam logic [639:0] c_font = {
    40'hF0909090F0, 40'h2060202070, 40'hF010F080F0, 40'hF010F010F0,
    40'h9090F01010, 40'hF080F010F0, 40'hF080F090F0, 40'hF010204040,
    40'hF090F090F0, 40'hF090F010F0, 40'hF090F09090, 40'hE090E090E0,
    40'hF0808080F0, 40'hE0909090E0, 40'hF080F080F0, 40'hF080F08080
  };
  localparam logic [6:0] c_font_last = 7'd79;

  logic [6:0] r_font_idx;
  logic [9:0] w_font_lsb;
  logic [7:0] w_font_byte;

  assign w_font_lsb  = 10'd632 - {r_font_idx, 3'b000};
  assign w_font_byte = c_font[w_font_lsb +: 8];
  assign w_prefill   = (r_state == ST_CLEAR) || (r_state == ST_FONT);
`else
  assign w_prefill   = (r_state == ST_CLEAR);
`endif

  assign w_rise     = ioctl_download & ~r_dl_q;
  assign w_start    = w_rise & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_in_range = (ioctl_addr < c_span);
  assign w_off_addr = BASE_ADDR + ioctl_addr[11:0];
  assign w_off_p1   = ioctl_addr[11:0] + 12'd1;

  // A strobe is honoured at the start edge, once while prefilling (into the
  // hold register), or any time in LOAD.
  assign w_take    = ioctl_wr & ioctl_download &
                     (w_start | (w_prefill & ~r_hold_vld) | (r_state == ST_LOAD));
  assign w_capture = w_take & w_in_range & (r_state != ST_LOAD);
  assign w_direct  = w_take & w_in_range & (r_state == ST_LOAD);

  assign w_size_base = w_start ? 12'd0 : r_rom_size;
  assign w_ovf_base  = w_start ? 1'b0  : r_overflow;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_we      = 1'b0;
    mem_addr    = 12'd0;
    mem_data    = 8'd0;
    mem_busy    = 1'b0;
    ioctl_wait  = 1'b0;
    load_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        mem_busy   = 1'b1;
        ioctl_wait = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = r_clr_addr;
        mem_data   = CLEAR_VALUE;
        if (r_clr_addr == MEM_TOP) begin
`ifdef CHIP8_FONT_PRELOAD_EN
          w_state_nxt = ST_FONT;
`else
          w_state_nxt = ST_LOAD;
`endif
        end
      end
`ifdef CHIP8_FONT_PRELOAD_EN
      ST_FONT: begin
        mem_busy   = 1'b1;
        ioctl_wait = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = {5'd0, r_font_idx};
        mem_data   = w_font_byte;
        if (r_font_idx == c_font_last) begin
          w_state_nxt = ST_LOAD;
        end
      end
`endif
      ST_LOAD: begin
        mem_busy   = 1'b1;
        ioctl_wait = r_hold_vld;
        if (r_hold_vld) begin
          mem_we   = 1'b1;
          mem_addr = r_hold_addr;
          mem_data = r_hold_data;
        end else if (r_wr_vld) begin
          mem_we   = 1'b1;
          mem_addr = r_wr_addr;
          mem_data = r_wr_data;
        end
        if (!ioctl_download && !r_hold_vld) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        mem_busy    = 1'b1;
        load_done   = 1'b1;
        w_state_nxt = w_rise ? ST_CLEAR : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_dl_q      <= 1'b0;
      r_clr_addr  <= BASE_ADDR;
      r_hold_vld  <= 1'b0;
      r_hold_addr <= 12'd0;
      r_hold_data <= 8'd0;
      r_wr_vld    <= 1'b0;
      r_wr_addr   <= 12'd0;
      r_wr_data   <= 8'd0;
      r_rom_size  <= 12'd0;
      r_overflow  <= 1'b0;
    end else begin
      r_dl_q <= ioctl_download;

      if (w_start) begin
        r_clr_addr <= BASE_ADDR;
      end else if (r_state == ST_CLEAR) begin
        r_clr_addr <= r_clr_addr + 12'd1;
      end

      // The hold entry is always written out on the first LOAD cycle.
      if (w_capture) begin
        r_hold_vld  <= 1'b1;
        r_hold_addr <= w_off_addr;
        r_hold_data <= ioctl_dout;
      end else if (r_state == ST_LOAD) begin
        r_hold_vld  <= 1'b0;
      end

      r_wr_vld <= w_direct;
      if (w_direct) begin
        r_wr_addr <= w_off_addr;
        r_wr_data <= ioctl_dout;
      end

      if (w_take && w_in_range) begin
        r_rom_size <= (w_off_p1 > w_size_base) ? w_off_p1 : w_size_base;
        r_overflow <= w_ovf_base;
      end else if (w_take) begin
        r_rom_size <= w_size_base;
        r_overflow <= 1'b1;
      end else begin
        r_rom_size <= w_size_base;
        r_overflow <= w_ovf_base;
      end
    end
  end

`ifdef CHIP8_FONT_PRELOAD_EN
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_font_idx <= 7'd0;
    end else if (r_state == ST_FONT) begin
      r_font_idx <= r_font_idx + 7'd1;
    end else begin
      r_font_idx <= 7'd0;
    end
  end
`endif

  assign rom_size = r_rom_size;
  assign overflow = r_overflow;

endmodule
`default_nettype wire
